nios2_frame_reader: RTL and testbench

- Avalon-MM read master that fetches a frame of 32-bit words, one word per read, from the on-chip frame memory's slave port.
- The memory holds a 320x240 frame of 76800 words.
- It re-emits the words as a packetised valid/ready stream (sop/eop) for the video output path.
- It is controlled by start/continuous inputs from Nios II PIO and reports busy and frame_done.

---
 rtl/nios2_frame_reader_pkg.sv | 21 ++
 rtl/nios2_frame_fifo.sv | 55 +++++
 rtl/nios2_frame_reader.sv | 157 +++++++++++++++
 tb/tb_nios2_frame_reader.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_frame_reader_pkg.sv
// Shared types and constants for the frame reader and its return FIFO.
package nios2_frame_reader_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    localparam int unsigned DEF_ADDR_W = 17;
    localparam int unsigned DEF_DATA_W = 32;

    // Every read fetches a full word.
    localparam logic [3:0] BYTEENABLE_ALL = 4'hF;

    // Width of a counter that spans 0..n-1, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nios2_frame_fifo.sv
// Synchronous first-word-fall-through FIFO holding read returns until the
// stream accepts them. The head word is visible whenever the FIFO is not empty.
module nios2_frame_fifo
    import nios2_frame_reader_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_DATA_W,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

    // A pop frees the slot in the same cycle, so push+pop on a full FIFO both happen.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/nios2_frame_reader.sv
// Avalon-MM read master that fetches a frame of words from the frame memory
// and replays them as a packetised valid/ready stream. Outstanding reads are
// limited by credits so every return always has a FIFO slot waiting for it.
module nios2_frame_reader
    import nios2_frame_reader_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned NUM_WORDS  = 76800,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              continuous,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              src_sop,
    output logic              src_eop
);

    localparam int unsigned      IDX_W    = idx_width(NUM_WORDS);
    localparam int unsigned      CRED_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(FIFO_DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic [CRED_W-1:0] credits_q, credits_d;
    logic              frame_done_q, frame_done_d;

    logic              rd_accept;
    logic              pop;
    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CRED_W-1:0] fifo_count;

    // Credits cover reads in flight plus FIFO occupancy, so a request only
    // issues when a slot is guaranteed for its return.
    assign avm_read       = (state_q == S_RUN) && (credits_q < CRED_MAX);
    assign avm_address    = addr_q;
    assign avm_byteenable = BYTEENABLE_ALL;
    assign rd_accept      = avm_read & ~avm_waitrequest;

    // Returns are only accepted while a credit is held for an in-flight read;
    // anything arriving after a reset finds no credit and is dropped.
    assign fifo_push  = avm_readdatavalid && (credits_q > fifo_count);

    assign src_valid  = ~fifo_empty;
    assign pop        = src_valid & src_ready;
    assign src_sop    = src_valid && (out_idx_q == '0);
    assign src_eop    = src_valid && (out_idx_q == LAST_IDX);
    assign busy       = (state_q != S_IDLE);
    assign frame_done = frame_done_q;

    nios2_frame_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .push_i      (fifo_push),
        .push_data_i (avm_readdata),
        .pop_i       (pop),
        .head_o      (src_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // State, read-pointer, stream-index and credit registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= BASE;
            rd_idx_q     <= '0;
            out_idx_q    <= '0;
            credits_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rd_idx_q     <= rd_idx_d;
            out_idx_q    <= out_idx_d;
            credits_q    <= credits_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic: address and index only move on an accepted read.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rd_idx_d = rd_idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    addr_d   = BASE;
                    rd_idx_d = '0;
                end
            end
            S_RUN: begin
                if (rd_accept) begin
                    if (rd_idx_q == LAST_IDX) begin
                        if (continuous) begin
                            addr_d   = BASE;
                            rd_idx_d = '0;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        addr_d   = addr_q + ADDR_W'(1);
                        rd_idx_d = rd_idx_q + IDX_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if ((credits_q == '0) && fifo_empty) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Credit accounting, output word index and end-of-frame pulse.
    always_comb begin
        credits_d    = credits_q;
        out_idx_d    = out_idx_q;
        frame_done_d = pop & src_eop;
        case ({rd_accept, pop})
            2'b10:   credits_d = credits_q + CRED_W'(1);
            2'b01:   credits_d = credits_q - CRED_W'(1);
            default: credits_d = credits_q;
        endcase
        if (pop) begin
            out_idx_d = (out_idx_q == LAST_IDX) ? '0 : out_idx_q + IDX_W'(1);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(fifo_push && fifo_full));
    a_credit_cap:  assert property (@(posedge clk) disable iff (reset) credits_q <= CRED_MAX);

endmodule

// File: tb/tb_nios2_frame_reader.sv
// Bench for nios2_frame_reader: a variable-latency memory slave, a queue of
// expected stream words, and a per-cycle monitor comparing the DUT to them.
module tb_nios2_frame_reader;

    localparam int unsigned NW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 17;
    localparam int unsigned DW    = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic          busy;
    logic          frame_done;
    logic [AW-1:0] avm_address;
    logic          avm_read;
    logic [3:0]    avm_byteenable;
    logic          avm_waitrequest;
    logic [DW-1:0] avm_readdata;
    logic          avm_readdatavalid;
    logic [DW-1:0] src_data;
    logic          src_valid;
    logic          src_ready = 1'b1;
    logic          src_sop;
    logic          src_eop;

    nios2_frame_reader #(
        .ADDR_W     (AW),
        .NUM_WORDS  (NW),
        .BASE_ADDR  (0),
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .continuous        (continuous),
        .busy              (busy),
        .frame_done        (frame_done),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .src_data          (src_data),
        .src_valid         (src_valid),
        .src_ready         (src_ready),
        .src_sop           (src_sop),
        .src_eop           (src_eop)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] data; bit sop; bit eop; } word_t;
    typedef struct { int unsigned addr; int unsigned due; } rd_t;

    word_t exp_q[$];
    rd_t   mq[$];

    int          checks = 0;
    int          failures = 0;
    int unsigned acc_addr = 0, acc_total = 0, pops = 0, frames = 0;
    int unsigned sop_pops = 0, eop_pops = 0;
    int unsigned sop_cyc = 0, eop_cyc = 0, busy_fall = 0, last_acc_cyc = 0;
    int          outstanding = 0;
    logic [31:0] last_sop_data = '0, last_eop_data = '0;
    bit          fd_exp = 0, prev_stall = 0, prev_busy = 0;
    logic [AW-1:0] prev_addr = '0;
    bit          gap_chk = 0;
    int unsigned gap_base = 0;

    bit          rand_wait = 0, rand_ready = 0;
    int unsigned lat_min = 1, lat_max = 1;

    // Frame memory contents seen by the bench.
    function automatic logic [31:0] mem_word(input int unsigned a);
        return 32'hF00D_0000 | ((a * 3) & 32'h0000_FFFF);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s at t=%0t", name, $time);
    endtask

    // Memory slave: in-order returns with latency lat_min..lat_max, optional random stalls.
    initial begin : mem_slave
        rd_t         r;
        int unsigned due;
        int unsigned last_due;
        last_due = 0;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        forever begin
            @(negedge clk);
            if (!reset && avm_read && !avm_waitrequest) begin
                due = cyc + $urandom_range(lat_max, lat_min);
                if (due <= last_due) due = last_due + 1;
                r.addr = int'(avm_address);
                r.due  = due;
                mq.push_back(r);
                last_due = due;
            end
            @(posedge clk);
            #1;
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                r = mq.pop_front();
                avm_readdatavalid = 1'b1;
                avm_readdata      = mem_word(r.addr);
            end else begin
                avm_readdatavalid = 1'b0;
                avm_readdata      = '0;
            end
            avm_waitrequest = rand_wait ? ($urandom_range(0, 1) == 1) : 1'b0;
        end
    end

    // Per-cycle monitor against the expected-word queue and bus rules.
    initial begin : monitor
        word_t w;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("reset_ctrl", {avm_read, src_valid, src_sop, src_eop, busy, frame_done}, '0);
                chk("reset_addr", avm_address, '0);
                exp_q.delete();
                acc_addr    = 0;
                outstanding = 0;
                fd_exp      = 0;
                prev_stall  = 0;
                prev_busy   = 0;
            end else begin
                chk("frame_done", frame_done, fd_exp);
                if (frame_done) frames++;
                fd_exp = 0;
                if (prev_busy && !busy) busy_fall = cyc;
                prev_busy = busy;
                if (prev_stall) begin
                    chk("stall_read", avm_read, 1);
                    chk("stall_addr", avm_address, prev_addr);
                end
                if (src_valid) begin
                    if (exp_q.size() == 0) begin
                        fail("extra_word");
                    end else begin
                        w = exp_q[0];
                        chk("src_data", src_data, w.data);
                        chk("src_sop", src_sop, w.sop);
                        chk("src_eop", src_eop, w.eop);
                        if (src_ready) begin
                            void'(exp_q.pop_front());
                            pops++;
                            outstanding--;
                            if (w.sop) begin sop_pops++; sop_cyc = cyc; last_sop_data = src_data; end
                            if (w.eop) begin eop_pops++; eop_cyc = cyc; last_eop_data = src_data; fd_exp = 1; end
                        end
                    end
                end
                if (avm_read && !avm_waitrequest) begin
                    chk("rd_addr", avm_address, acc_addr % NW);
                    if (gap_chk && acc_addr > gap_base && ((acc_addr - gap_base) % NW) == 0)
                        chk("wrap_gap", cyc - last_acc_cyc, 1);
                    last_acc_cyc = cyc;
                    acc_addr++;
                    acc_total++;
                    outstanding++;
                end
                chk("credit_bound", outstanding <= int'(DEPTH), 1);
                prev_stall = avm_read && avm_waitrequest;
                prev_addr  = avm_address;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) src_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic pulse_start(input bit expect_frames, input int unsigned nframes);
        word_t w;
        if (expect_frames) begin
            for (int unsigned f = 0; f < nframes; f++) begin
                for (int unsigned k = 0; k < NW; k++) begin
                    w.data = mem_word(k);
                    w.sop  = (k == 0);
                    w.eop  = (k == NW - 1);
                    exp_q.push_back(w);
                end
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned bound, input string name);
        int unsigned n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        if (busy || exp_q.size() != 0) fail(name);
        repeat (3) tick();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int unsigned a0, f0, s0, e0, p0, n;

        // Reset state.
        repeat (3) tick();
        chk("byteenable", avm_byteenable, 4'hF);
        reset = 1'b0;
        repeat (2) tick();
        chk("idle_busy", busy, 0);
        chk("mem_word_pin", mem_word(5), 32'hF00D_000F);

        // Single frame, latency 1, no back-pressure.
        a0 = acc_total; f0 = frames; s0 = sop_pops; e0 = eop_pops;
        pulse_start(1, 1);
        wait_idle(200, "t1_timeout");
        chk("t1_reads", acc_total - a0, NW);
        chk("t1_frames", frames - f0, 1);
        chk("t1_sop_count", sop_pops - s0, 1);
        chk("t1_eop_count", eop_pops - e0, 1);
        chk("t1_sop_word", last_sop_data, 32'hF00D_0000);
        chk("t1_eop_word", last_eop_data, 32'hF00D_002D);
        chk("t1_throughput", eop_cyc - sop_cyc, NW - 1);
        chk("t1_busy_drop", (busy_fall > eop_cyc) && (busy_fall - eop_cyc <= 3), 1);

        // Back-pressure for 20 cycles after start.
        a0 = acc_total; f0 = frames;
        src_ready = 1'b0;
        pulse_start(1, 1);
        repeat (19) tick();
        chk("t2_reads_held", acc_total - a0, DEPTH);
        chk("t2_read_low", avm_read, 0);
        chk("t2_valid_held", src_valid, 1);
        src_ready = 1'b1;
        wait_idle(300, "t2_timeout");
        chk("t2_reads", acc_total - a0, NW);
        chk("t2_frames", frames - f0, 1);

        // Random stalls, latency 1..4, random ready.
        a0 = acc_total; f0 = frames;
        rand_wait = 1; rand_ready = 1; lat_min = 1; lat_max = 4;
        pulse_start(1, 1);
        wait_idle(3000, "t3_timeout");
        rand_wait = 0; rand_ready = 0; lat_max = 1; src_ready = 1'b1;
        repeat (6) tick();
        chk("t3_reads", acc_total - a0, NW);
        chk("t3_frames", frames - f0, 1);

        // Continuous for three frames, then stop.
        a0 = acc_total; f0 = frames; s0 = sop_pops; e0 = eop_pops;
        continuous = 1'b1;
        gap_base = acc_addr;
        gap_chk = 1;
        pulse_start(1, 3);
        n = 0;
        while (acc_total - a0 < 2 * NW + 1 && n < 300) begin tick(); n++; end
        if (acc_total - a0 < 2 * NW + 1) fail("t4_third_frame_timeout");
        continuous = 1'b0;
        wait_idle(400, "t4_timeout");
        gap_chk = 0;
        chk("t4_reads", acc_total - a0, 3 * NW);
        chk("t4_frames", frames - f0, 3);
        chk("t4_sops", sop_pops - s0, 3);
        chk("t4_eops", eop_pops - e0, 3);
        chk("t4_idle", busy, 0);

        // Reset mid-frame with reads in flight.
        lat_min = 3; lat_max = 3;
        p0 = pops;
        pulse_start(1, 1);
        n = 0;
        while (pops - p0 < 7 && n < 200) begin tick(); n++; end
        if (pops - p0 < 7) fail("t5_word7_timeout");
        reset = 1'b1;
        #1;
        chk("t5_async_ctrl", {avm_read, src_valid, src_sop, src_eop, busy, frame_done}, '0);
        chk("t5_async_addr", avm_address, '0);
        chk("t5_stale_pending", mq.size() > 0, 1);
        tick();
        reset = 1'b0;
        repeat (8) tick();
        chk("t5_stale_drained", mq.size(), 0);
        chk("t5_idle_after", {busy, src_valid}, 2'b00);
        lat_min = 1; lat_max = 1;
        a0 = acc_total; f0 = frames; s0 = sop_pops;
        pulse_start(1, 1);
        wait_idle(200, "t5_timeout");
        chk("t5_reads", acc_total - a0, NW);
        chk("t5_frames", frames - f0, 1);
        chk("t5_sop_word", last_sop_data, 32'hF00D_0000);
        chk("t5_sop_count", sop_pops - s0, 1);

        // Start while busy is ignored.
        a0 = acc_total; f0 = frames;
        pulse_start(1, 1);
        repeat (5) tick();
        pulse_start(0, 0);
        wait_idle(200, "t6_timeout");
        chk("t6_reads", acc_total - a0, NW);
        chk("t6_frames", frames - f0, 1);
        chk("t6_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
